// File: rtl/vc_fifo_head_mc.sv
// Multi-channel valid/credit FIFO head.
// Producer side of N independent FIFOs sharing one RAM write port; channel c owns
// RAM addresses c*depth .. c*depth+depth-1. Each channel keeps its own write pointer,
// outstanding-credit count and sticky overflow flag, so no credit-honouring producer
// can ever overrun a tail FIFO.
// Optional feature macro: VC_FIFO_HEAD_MC_HIWAT_EN adds a per-channel usage
// high-water mark output (hiwat). Left undefined, the port and its registers are absent.

// Per-channel slice: pointer, credit counter, credit pulse and overflow flag.
module vc_fifo_head_ch #(
  parameter int depth = 16,
  parameter int asz   = $clog2(depth)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         v,
  input  logic [asz:0] rdptr,
  output logic         we,
  output logic         cr,
  output logic         ovf,
  output logic [asz:0] wrptr,
  output logic [asz:0] usage
`ifdef VC_FIFO_HEAD_MC_HIWAT_EN
  ,
  output logic [asz:0] hiwat
`endif
);

  // Credit math is one bit wider than the pointers so cnt + occ (up to 2*depth) never wraps.
  logic [asz+1:0] cissued, cnt_nxt, occ_nxt, cr_sum;
  logic [asz:0]   nxt_wrptr, occ_diff;
  logic           full, starve, cr_nxt;

  // Occupancy, write gating and next-cycle credit decision.
  always_comb begin
    usage     = wrptr - rdptr;
    full      = (usage == (asz+1)'(depth));
    we        = v & ~full;
    nxt_wrptr = wrptr + {{asz{1'b0}}, we};
    // A strobe with no credit held is a protocol error; the counter pins at zero.
    starve    = v & (cissued == '0);
    cnt_nxt   = starve ? '0 : (cissued - {{(asz+1){1'b0}}, v});
    occ_diff  = nxt_wrptr - rdptr;
    occ_nxt   = {1'b0, occ_diff};
    cr_sum    = cnt_nxt + occ_nxt;
    cr_nxt    = (cr_sum < (asz+2)'(depth));
  end

  // Pointer, credit and overflow state; reset wins over any traffic.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wrptr   <= '0;
      cissued <= '0;
      cr      <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      wrptr   <= nxt_wrptr;
      cissued <= cnt_nxt + {{(asz+1){1'b0}}, cr_nxt};
      cr      <= cr_nxt;
      if (starve | (v & full)) ovf <= 1'b1;
    end
  end

`ifdef VC_FIFO_HEAD_MC_HIWAT_EN
  // Track the largest occupancy seen since reset.
  always_ff @(posedge clk) begin
    if (!reset_n)          hiwat <= '0;
    else if (usage > hiwat) hiwat <= usage;
  end
`endif

endmodule

module vc_fifo_head_mc #(
  parameter int channels = 4,
  parameter int depth    = 16,
  parameter int asz      = $clog2(depth),
  parameter int csz      = $clog2(channels)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          c_vld,
  input  logic [csz-1:0]                c_chan,
  output logic [channels-1:0]           c_cr,
  output logic                          wr_en,
  output logic [csz+asz-1:0]            wr_addr,
  output logic [channels*(asz+1)-1:0]   wrptr_head,
  input  logic [channels*(asz+1)-1:0]   rdptr_tail,
  output logic [channels*(asz+1)-1:0]   usage,
  output logic [channels-1:0]           overflow
`ifdef VC_FIFO_HEAD_MC_HIWAT_EN
  ,
  output logic [channels*(asz+1)-1:0]   hiwat
`endif
);

  logic [channels-1:0]          sel, we;
  logic [channels-1:0][asz:0]   wrptr, occ;
`ifdef VC_FIFO_HEAD_MC_HIWAT_EN
  logic [channels-1:0][asz:0]   hw;
  assign hiwat = hw;
`endif

  for (genvar g = 0; g < channels; g++) begin : g_ch
    assign sel[g] = c_vld & (c_chan == csz'(g));
    vc_fifo_head_ch #(.depth(depth), .asz(asz)) u_ch (
      .clk    (clk),
      .reset_n(reset_n),
      .v      (sel[g]),
      .rdptr  (rdptr_tail[g*(asz+1) +: asz+1]),
      .we     (we[g]),
      .cr     (c_cr[g]),
      .ovf    (overflow[g]),
      .wrptr  (wrptr[g]),
      .usage  (occ[g])
`ifdef VC_FIFO_HEAD_MC_HIWAT_EN
      ,
      .hiwat  (hw[g])
`endif
    );
  end

  assign wrptr_head = wrptr;
  assign usage      = occ;
  // At most one channel is selected, so the OR is the selected channel's enable.
  assign wr_en      = |we;

  // RAM address: channel index on top, selected channel's pointer (sans wrap bit) below.
  always_comb begin
    wr_addr = '0;
    for (int c = 0; c < channels; c++)
      if (c_chan == csz'(c)) wr_addr = {c_chan, wrptr[c][asz-1:0]};
  end

endmodule

// File: tb/tb_vc_fifo_head_mc.sv
// Directed bench for vc_fifo_head_mc (channels=4, depth=16).
module tb_vc_fifo_head_mc;
  localparam int CH = 4, DP = 16, ASZ = 4, CSZ = 2, PW = ASZ + 1;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              c_vld = 1'b0;
  logic [CSZ-1:0]    c_chan = '0;
  logic [CH-1:0]     c_cr;
  logic              wr_en;
  logic [CSZ+ASZ-1:0] wr_addr;
  logic [CH*PW-1:0]  wrptr_head;
  logic [CH*PW-1:0]  rdptr_tail = '0;
  logic [CH*PW-1:0]  usage;
  logic [CH-1:0]     overflow;
`ifdef VC_FIFO_HEAD_MC_HIWAT_EN
  logic [CH*PW-1:0]  hiwat;
`endif

  int vectors = 0;
  int miscompares = 0;
  int exp_wr;

  always #5 clk = ~clk;

  vc_fifo_head_mc #(.channels(CH), .depth(DP)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .c_vld     (c_vld),
    .c_chan    (c_chan),
    .c_cr      (c_cr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wrptr_head(wrptr_head),
    .rdptr_tail(rdptr_tail),
    .usage     (usage),
    .overflow  (overflow)
`ifdef VC_FIFO_HEAD_MC_HIWAT_EN
    ,
    .hiwat     (hiwat)
`endif
  );

  function automatic logic [31:0] fld(input logic [CH*PW-1:0] v, input int c);
    return 32'(v[c*PW +: PW]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int c, input int val);
    rdptr_tail[c*PW +: PW] = PW'(val);
  endtask

  initial begin
    // 1: reset, then idle credit ramp
    tick(); tick();
    chk("rst_cr", 32'(c_cr), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_wrptr", 32'(wrptr_head), 32'h0);
    chk("rst_usage", 32'(usage), 32'h0);
    reset_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk("ramp_cr", 32'(c_cr), (i <= 16) ? 32'hF : 32'h0);
    end
    chk("ramp_usage", 32'(usage), 32'h0);

    // 2: sixteen writes to channel 2
    for (int i = 0; i < 16; i++) begin
      c_vld = 1'b1; c_chan = 2'd2;
      #1;
      chk("w2_en", 32'(wr_en), 32'h1);
      chk("w2_addr", 32'(wr_addr), 32'h20 + 32'(i));
      tick();
      chk("w2_cr", 32'(c_cr), 32'h0);
    end
    c_vld = 1'b0;
    tick();
    chk("w2_usage2", fld(usage, 2), 32'd16);
    chk("w2_usage0", fld(usage, 0), 32'd0);
    chk("w2_usage1", fld(usage, 1), 32'd0);
    chk("w2_usage3", fld(usage, 3), 32'd0);
    chk("w2_wrptr2", fld(wrptr_head, 2), 32'd16);
    chk("w2_wrptr3", fld(wrptr_head, 3), 32'd0);
`ifdef VC_FIFO_HEAD_MC_HIWAT_EN
    chk("w2_hiwat2", fld(hiwat, 2), 32'd16);
`endif

    // 3: tail reads 3 entries of channel 2 -> exactly 3 credit pulses
    set_rd(2, 3);
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("rd3_cr", 32'(c_cr), (i <= 3) ? 32'h4 : 32'h0);
    end
    chk("rd3_usage2", fld(usage, 2), 32'd13);
    for (int i = 0; i < 3; i++) begin
      c_vld = 1'b1; c_chan = 2'd2;
      #1;
      chk("refill_en", 32'(wr_en), 32'h1);
      chk("refill_addr", 32'(wr_addr), 32'h20 + 32'(i));
      tick();
      chk("refill_cr", 32'(c_cr), 32'h0);
    end
    c_vld = 1'b0;
    chk("refill_usage2", fld(usage, 2), 32'd16);

    // 4: write to full channel 2 is dropped and flagged
    c_vld = 1'b1; c_chan = 2'd2;
    #1;
    chk("ovf_wr_en", 32'(wr_en), 32'h0);
    tick();
    c_vld = 1'b0;
    chk("ovf_wrptr2", fld(wrptr_head, 2), 32'd19);
    chk("ovf_flag", 32'(overflow), 32'h4);
    tick(); tick(); tick();
    chk("ovf_sticky", 32'(overflow), 32'h4);
    chk("ovf_usage2", fld(usage, 2), 32'd16);

    // 5: streaming channel 1, one write and one read per cycle, pointers wrap
    c_vld = 1'b1; c_chan = 2'd1;
    #1;
    chk("s1_prime_addr", 32'(wr_addr), 32'h10);
    tick();
    exp_wr = 1;
    for (int i = 1; i <= 40; i++) begin
      chk("s1_usage1", fld(usage, 1), 32'd1);
      set_rd(1, i % 32);
      #1;
      chk("s1_en", 32'(wr_en), 32'h1);
      chk("s1_addr", 32'(wr_addr), 32'h10 + 32'(exp_wr % 16));
      tick();
      exp_wr++;
      chk("s1_wrptr1", fld(wrptr_head, 1), 32'(exp_wr % 32));
      chk("s1_cr", 32'(c_cr), 32'h2);
    end
    chk("s1_wrap", fld(wrptr_head, 1), 32'd9);
    chk("s1_ch2_wrptr", fld(wrptr_head, 2), 32'd19);
    chk("s1_ch2_usage", fld(usage, 2), 32'd16);
    chk("s1_ovf", 32'(overflow), 32'h4);

    // 6: reset in the middle of the stream
    set_rd(1, 9);
    tick();
    reset_n = 1'b0; c_vld = 1'b0; rdptr_tail = '0;
    tick();
    chk("mrst_cr", 32'(c_cr), 32'h0);
    chk("mrst_ovf", 32'(overflow), 32'h0);
    chk("mrst_wrptr", 32'(wrptr_head), 32'h0);
    chk("mrst_usage", 32'(usage), 32'h0);
    chk("mrst_wr_en", 32'(wr_en), 32'h0);
`ifdef VC_FIFO_HEAD_MC_HIWAT_EN
    chk("mrst_hiwat", 32'(hiwat), 32'h0);
`endif
    reset_n = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      tick();
      chk("mrst_ramp_cr", 32'(c_cr), (i <= 16) ? 32'hF : 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
